// File: rtl/pll_rst_ctrl_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
// Consumed by pll_rst_ctrl and sync_2ff.
package pll_rst_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_rst_state_e;

  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_TIMEOUT = 50000;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_CNT_W        = 16;

  localparam int          LOSS_CNT_W   = 8;
  localparam logic [7:0]  LOSS_CNT_MAX = 8'hFF;

  // Outputs that assert PLL reset: the reset pulse itself and the parked FAIL state.
  function automatic logic holds_pll_rst(pll_rst_state_e st);
    return (st == ST_RESET) || (st == ST_FAIL);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
// Reset value of both stages is 0.
module sync_2ff
  import pll_rst_ctrl_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses PLL reset, qualifies lock,
// releases the system reset. Optional lock-loss counter: PLL_RST_CTRL_LOSS_CNT_EN.
module pll_rst_ctrl
  import pll_rst_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int CNT_W        = DEF_CNT_W,
  localparam int RETRY_W     = $clog2(MAX_RETRY + 1)
) (
  input  logic                  clkin1,
  input  logic                  rst_n,
  input  logic                  pll_lock_i,
  input  logic                  soft_rst_i,
  output logic                  pll_rst_o,
  output logic                  sys_rst_n_o,
  output logic                  locked_o,
  output logic                  fail_o,
  output logic [RETRY_W-1:0]    retry_o,
  output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  logic lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clkin1),
    .rst_n (rst_n),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );

  pll_rst_state_e     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               locked_q, locked_d;
  logic               fail_q, fail_d;
  logic               lock_loss;

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    lock_loss = 1'b0;

    unique case (state_q)
      ST_RESET: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
        end
      end
      ST_STABLE: begin
        if (!lock_s)                  state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d   = ST_RESET;
          lock_loss = 1'b1;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RESET;
    endcase

    if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;

    // Soft reset overrides whatever the FSM decided this cycle.
    if (soft_rst_i) begin
      state_d   = ST_RESET;
      retry_d   = '0;
      lock_loss = 1'b0;
    end

    // Counter restarts on every entry; it idles in RUN and FAIL where it is unused.
    if (soft_rst_i || state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN || state_q == ST_FAIL) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    pll_rst_d   = holds_pll_rst(state_d);
    sys_rst_n_d = (state_d == ST_RUN);
    locked_d    = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  always_ff @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign locked_o    = locked_q;
  assign fail_o      = fail_q;
  assign retry_o     = retry_q;

`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_loss && loss_cnt_q != LOSS_CNT_MAX) loss_cnt_d = loss_cnt_q + 1'b1;
  end

  always_ff @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) loss_cnt_q <= '0;
    else        loss_cnt_q <= loss_cnt_d;
  end

  assign loss_cnt_o = loss_cnt_q;
`else
  logic unused_lock_loss;
  assign unused_lock_loss = lock_loss;
  assign loss_cnt_o       = '0;
`endif

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Self-checking bench for pll_rst_ctrl: directed timing scenarios plus a
// randomized lock/soft-reset run compared against a countdown-based model.
module tb_pll_rst_ctrl;

  localparam int RST = 4;
  localparam int TO  = 100;
  localparam int ST  = 8;
  localparam int MR  = 2;
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock_i;
  logic       soft_rst_i;
  logic       pll_rst_o;
  logic       sys_rst_n_o;
  logic       locked_o;
  logic       fail_o;
  logic [1:0] retry_o;
  logic [7:0] loss_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_rst_ctrl #(
    .RST_CYCLES   (RST),
    .LOCK_TIMEOUT (TO),
    .LOCK_STABLE  (ST),
    .MAX_RETRY    (MR),
    .CNT_W        (16)
  ) dut (
    .clkin1      (clk),
    .rst_n       (rst_n),
    .pll_lock_i  (pll_lock_i),
    .soft_rst_i  (soft_rst_i),
    .pll_rst_o   (pll_rst_o),
    .sys_rst_n_o (sys_rst_n_o),
    .locked_o    (locked_o),
    .fail_o      (fail_o),
    .retry_o     (retry_o),
    .loss_cnt_o  (loss_cnt_o)
  );

  // Reference model: phase 0=reset pulse, 1=waiting for lock, 2=qualifying,
  // 3=running, 4=failed; m_left counts down the cycles remaining in a phase.
  int m_phase, m_left, m_retry, m_loss;
  bit m_d1, m_d2;

  function automatic void model_enter(int p);
    m_phase = p;
    m_left  = (p == 0) ? RST : (p == 1) ? TO : (p == 2) ? ST : 0;
  endfunction

  function automatic void model_reset();
    model_enter(0);
    m_retry = 0;
    m_loss  = 0;
    m_d1    = 1'b0;
    m_d2    = 1'b0;
  endfunction

  function automatic void model_edge();
    bit seen;
    if (!rst_n) begin
      model_reset();
      return;
    end
    seen = m_d2;
    m_d2 = m_d1;
    m_d1 = pll_lock_i;
    if (soft_rst_i) begin
      model_enter(0);
      m_retry = 0;
      return;
    end
    case (m_phase)
      0: begin
        m_left--;
        if (m_left == 0) model_enter(1);
      end
      1: begin
        if (seen) model_enter(2);
        else begin
          m_left--;
          if (m_left == 0) begin
            m_retry++;
            model_enter((m_retry == MR) ? 4 : 0);
          end
        end
      end
      2: begin
        if (!seen) model_enter(1);
        else begin
          m_left--;
          if (m_left == 0) begin
            model_enter(3);
            m_retry = 0;
          end
        end
      end
      3: begin
        if (!seen) begin
          model_enter(0);
          if (LOSS_EN && m_loss < 255) m_loss++;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset(input logic lock);
    rst_n      = 1'b0;
    soft_rst_i = 1'b0;
    pll_lock_i = lock;
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    rst_n = 1'b0;
    model_reset();
    cyc();
    total++;
    if ({pll_rst_o, sys_rst_n_o, locked_o, fail_o} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=1000", {pll_rst_o, sys_rst_n_o, locked_o, fail_o});
    end
    total++;
    if (retry_o !== 2'd0 || loss_cnt_o !== 8'd0) begin
      bad++;
      $display("FAIL reset_counts got retry=%0d loss=%0d want 0/0", retry_o, loss_cnt_o);
    end
    $display("test_reset checked");
  endtask

  task automatic test_powerup();
    apply_reset(1'b1);
    for (int e = 1; e <= 13; e++) begin
      cyc();
      total++;
      if (pll_rst_o !== (e < RST)) begin
        bad++;
        $display("FAIL powerup_pll_rst edge=%0d got=%b want=%b", e, pll_rst_o, (e < RST));
      end
      total++;
      if (sys_rst_n_o !== (e >= 13) || locked_o !== (e >= 13)) begin
        bad++;
        $display("FAIL powerup_release edge=%0d got sys=%b lock=%b want=%b", e, sys_rst_n_o, locked_o, (e >= 13));
      end
    end
    total++;
    if (retry_o !== 2'd0) begin
      bad++;
      $display("FAIL powerup_retry got=%0d want=0", retry_o);
    end
    $display("test_powerup checked");
  endtask

  task automatic test_lock_loss();
    logic [7:0] want_loss;
    pll_lock_i = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      total++;
      if (sys_rst_n_o !== (e < 3)) begin
        bad++;
        $display("FAIL loss_sys_rst edge=%0d got=%b want=%b", e, sys_rst_n_o, (e < 3));
      end
      total++;
      if (pll_rst_o !== (e >= 3 && e < 3 + RST)) begin
        bad++;
        $display("FAIL loss_pll_rst edge=%0d got=%b want=%b", e, pll_rst_o, (e >= 3 && e < 3 + RST));
      end
    end
    want_loss = LOSS_EN ? 8'd1 : 8'd0;
    total++;
    if (loss_cnt_o !== want_loss) begin
      bad++;
      $display("FAIL loss_count got=%0d want=%0d", loss_cnt_o, want_loss);
    end
    $display("test_lock_loss checked");
  endtask

  task automatic test_timeout();
    apply_reset(1'b0);
    for (int e = 1; e <= 212; e++) begin
      logic       want_rst;
      logic [1:0] want_retry;
      cyc();
      want_rst   = (e < RST) || (e >= RST + TO && e < 2 * RST + TO) || (e >= 2 * (RST + TO));
      want_retry = (e >= 2 * (RST + TO)) ? 2'd2 : (e >= RST + TO) ? 2'd1 : 2'd0;
      total++;
      if (pll_rst_o !== want_rst || retry_o !== want_retry || fail_o !== (e >= 2 * (RST + TO))) begin
        bad++;
        $display("FAIL timeout edge=%0d got rst=%b retry=%0d fail=%b want rst=%b retry=%0d fail=%b",
                 e, pll_rst_o, retry_o, fail_o, want_rst, want_retry, (e >= 2 * (RST + TO)));
      end
    end
    $display("test_timeout checked");
  endtask

  task automatic test_soft_from_fail();
    pll_lock_i = 1'b1;
    soft_rst_i = 1'b1;
    cyc();
    soft_rst_i = 1'b0;
    total++;
    if (fail_o !== 1'b0 || retry_o !== 2'd0 || pll_rst_o !== 1'b1) begin
      bad++;
      $display("FAIL soft_clear got fail=%b retry=%0d rst=%b want 0/0/1", fail_o, retry_o, pll_rst_o);
    end
    for (int e = 2; e <= 14; e++) begin
      cyc();
      total++;
      if (pll_rst_o !== (e < 1 + RST) || sys_rst_n_o !== (e >= 14)) begin
        bad++;
        $display("FAIL soft_sequence edge=%0d got rst=%b sys=%b want rst=%b sys=%b",
                 e, pll_rst_o, sys_rst_n_o, (e < 1 + RST), (e >= 14));
      end
    end
    $display("test_soft_from_fail checked");
  endtask

  task automatic test_glitch();
    apply_reset(1'b1);
    for (int e = 1; e <= 20; e++) begin
      cyc();
      if (e == 7) pll_lock_i = 1'b0;
      if (e == 8) pll_lock_i = 1'b1;
      total++;
      if (sys_rst_n_o !== (e >= 19) || retry_o !== 2'd0) begin
        bad++;
        $display("FAIL glitch edge=%0d got sys=%b retry=%0d want sys=%b retry=0",
                 e, sys_rst_n_o, retry_o, (e >= 19));
      end
    end
    $display("test_glitch checked");
  endtask

  task automatic test_async_rst();
    apply_reset(1'b1);
    repeat (6) cyc();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({pll_rst_o, sys_rst_n_o, locked_o, fail_o} !== 4'b1000 || retry_o !== 2'd0) begin
      bad++;
      $display("FAIL async_rst got flags=%b retry=%0d want 1000/0",
               {pll_rst_o, sys_rst_n_o, locked_o, fail_o}, retry_o);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      cyc();
      total++;
      if (pll_rst_o !== (e < RST) || sys_rst_n_o !== (e >= 13)) begin
        bad++;
        $display("FAIL async_restart edge=%0d got rst=%b sys=%b want rst=%b sys=%b",
                 e, pll_rst_o, sys_rst_n_o, (e < RST), (e >= 13));
      end
    end
    $display("test_async_rst checked");
  endtask

  task automatic test_random();
    int run_left = 0;
    int shown    = 0;
    apply_reset(1'b0);
    for (int i = 0; i < 5000; i++) begin
      logic [13:0] got, want;
      if (run_left == 0) begin
        pll_lock_i = $urandom_range(0, 1);
        run_left   = pll_lock_i ? $urandom_range(1, 200) : $urandom_range(1, 140);
      end
      run_left--;
      soft_rst_i = ($urandom_range(0, 299) == 0);
      cyc();
      got  = {pll_rst_o, sys_rst_n_o, locked_o, fail_o, retry_o, loss_cnt_o};
      want = {(m_phase == 0 || m_phase == 4), (m_phase == 3), (m_phase == 3), (m_phase == 4),
              2'(m_retry), 8'(m_loss)};
      total++;
      if (got !== want) begin
        bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cycle=%0d got=%b want=%b", i, got, want);
        end
      end
    end
    soft_rst_i = 1'b0;
    $display("test_random checked");
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_lock_i = 1'b0;
    soft_rst_i = 1'b0;
    model_reset();
    test_reset();
    test_powerup();
    test_lock_loss();
    test_timeout();
    test_soft_from_fail();
    test_glitch();
    test_async_rst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
